// File: rtl/nand_cmd_sequencer.sv
// NAND flash bus sequencer: expands one high-level request into CLE/ALE/WE#/RE# bus cycles,
// waits on R/B#, and streams read bytes out over a valid/ready handshake.
module nand_cmd_sequencer #(
  parameter int unsigned T_WE_LO    = 8,
  parameter int unsigned T_WE_HI    = 8,
  parameter int unsigned T_RE_LO    = 10,
  parameter int unsigned T_RE_HI    = 8,
  parameter int unsigned T_WB       = 40,
  parameter int unsigned RB_TIMEOUT = 400000
) (
  input  logic        hw_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_col,
  input  logic [23:0] req_row,
  input  logic [11:0] req_len,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic        nand_ce_n,
  output logic        nand_cle,
  output logic        nand_ale,
  output logic        nand_we_n,
  output logic        nand_re_n,
  output logic [7:0]  nand_dq_out,
  output logic        nand_dq_oe,
  input  logic [7:0]  nand_dq_in,
  input  logic        nand_rb_n
);

  typedef enum logic [3:0] {
    StIdle, StCmd1, StAddr, StCmd2, StWaitWb, StWaitRb, StRdByte, StRdHold, StDone
  } state_e;

  localparam logic [1:0] OpReset    = 2'd0;
  localparam logic [1:0] OpReadId   = 2'd1;
  localparam logic [1:0] OpReadPage = 2'd2;
  localparam logic [1:0] OpStatus   = 2'd3;

  // One shared timer; wide enough for the longest interval (the R/B# timeout).
  localparam int unsigned CntW =
      $clog2(RB_TIMEOUT + T_WB + T_WE_LO + T_WE_HI + T_RE_LO + T_RE_HI + 2);
  localparam logic [CntW-1:0] WeLo    = CntW'(T_WE_LO);
  localparam logic [CntW-1:0] WeEnd   = CntW'(T_WE_LO + T_WE_HI - 1);
  localparam logic [CntW-1:0] WbEnd   = CntW'(T_WB - 1);
  localparam logic [CntW-1:0] ReLoEnd = CntW'(T_RE_LO - 1);
  localparam logic [CntW-1:0] ReHiEnd = CntW'(T_RE_HI - 1);
  localparam logic [CntW-1:0] RbMax   = CntW'(RB_TIMEOUT);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      addr_idx_q;
  logic [1:0]      op_q;
  logic [15:0]     col_q;
  logic [23:0]     row_q;
  logic [11:0]     rem_q;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic            timeout_q;
  logic            rb_meta_q, rb_sync_q;

  logic       byte_end, addr_last, rb_expired, capture, hold_done;
  logic [7:0] cmd1_byte, addr_byte;

  assign byte_end   = (cnt_q == WeEnd);
  assign addr_last  = (op_q == OpReadId) ? (addr_idx_q == 3'd0) : (addr_idx_q == 3'd4);
  assign rb_expired = (cnt_q >= RbMax);
  assign capture    = (state_q == StRdByte) && (cnt_q == ReLoEnd);
  // RE# high time has elapsed and the presented byte is gone (or leaves this edge).
  assign hold_done  = (cnt_q >= ReHiEnd) && (!rd_valid_q || rd_ready);

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StCmd1;
      StCmd1: begin
        if (byte_end) begin
          state_d = (op_q == OpReadId || op_q == OpReadPage) ? StAddr : StWaitWb;
        end
      end
      StAddr: begin
        if (byte_end && addr_last) state_d = (op_q == OpReadPage) ? StCmd2 : StWaitWb;
      end
      StCmd2:   if (byte_end) state_d = StWaitWb;
      StWaitWb: begin
        if (cnt_q == WbEnd) begin
          if (op_q == OpReset || op_q == OpReadPage) state_d = StWaitRb;
          else if (rem_q == '0)                      state_d = StDone;
          else                                       state_d = StRdByte;
        end
      end
      StWaitRb: begin
        if (rb_sync_q) begin
          state_d = (op_q == OpReset || rem_q == '0) ? StDone : StRdByte;
        end else if (rb_expired) begin
          state_d = StIdle;
        end
      end
      StRdByte: if (capture) state_d = StRdHold;
      StRdHold: if (hold_done) state_d = (rem_q == '0) ? StDone : StRdByte;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      addr_idx_q <= '0;
      op_q       <= OpReset;
      col_q      <= '0;
      row_q      <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_d != state_q || (state_q == StAddr && byte_end)) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (state_q == StIdle && req_valid) begin
        op_q       <= req_op;
        col_q      <= req_col;
        row_q      <= req_row;
        rem_q      <= (req_op == OpReset) ? 12'd0 : (req_op == OpStatus) ? 12'd1 : req_len;
        addr_idx_q <= '0;
        timeout_q  <= 1'b0;
      end
      if (state_q == StAddr && byte_end) addr_idx_q <= addr_idx_q + 3'd1;
      if (state_q == StWaitRb && !rb_sync_q && rb_expired) timeout_q <= 1'b1;
      if (capture) begin
        rd_data_q  <= nand_dq_in;
        rd_valid_q <= 1'b1;
        rem_q      <= rem_q - 12'd1;
      end else if (rd_valid_q && rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      rb_meta_q <= nand_rb_n;
      rb_sync_q <= rb_meta_q;
    end
  end

  always_comb begin
    cmd1_byte = 8'h00;
    unique case (op_q)
      OpReset:    cmd1_byte = 8'hFF;
      OpReadId:   cmd1_byte = 8'h90;
      OpReadPage: cmd1_byte = 8'h00;
      OpStatus:   cmd1_byte = 8'h70;
      default:    cmd1_byte = 8'h00;
    endcase
    addr_byte = 8'h00;
    if (op_q == OpReadPage) begin
      case (addr_idx_q)
        3'd0:    addr_byte = col_q[7:0];
        3'd1:    addr_byte = col_q[15:8];
        3'd2:    addr_byte = row_q[7:0];
        3'd3:    addr_byte = row_q[15:8];
        3'd4:    addr_byte = row_q[23:16];
        default: addr_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    nand_ce_n   = 1'b0;
    nand_cle    = 1'b0;
    nand_ale    = 1'b0;
    nand_we_n   = 1'b1;
    nand_re_n   = 1'b1;
    nand_dq_out = 8'h00;
    nand_dq_oe  = 1'b0;
    req_ready   = (state_q == StIdle);
    busy        = (state_q != StIdle);
    unique case (state_q)
      StIdle, StDone: nand_ce_n = 1'b1;
      StCmd1: begin
        nand_cle    = 1'b1;
        nand_dq_oe  = 1'b1;
        nand_dq_out = cmd1_byte;
        nand_we_n   = (cnt_q >= WeLo);
      end
      StAddr: begin
        nand_ale    = 1'b1;
        nand_dq_oe  = 1'b1;
        nand_dq_out = addr_byte;
        nand_we_n   = (cnt_q >= WeLo);
      end
      StCmd2: begin
        nand_cle    = 1'b1;
        nand_dq_oe  = 1'b1;
        nand_dq_out = 8'h30;
        nand_we_n   = (cnt_q >= WeLo);
      end
      StRdByte: nand_re_n = 1'b0;
      default: ;
    endcase
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign timeout_err = timeout_q;

endmodule
